// File: rtl/fpu_addsub_issuer.sv
// fpu_addsub_issuer: queues FP add/sub requests and issues them one at a time to an addsub unit,
// returning result, overflow and timeout through a valid/ready response port.
module fpu_addsub_issuer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [31:0]                  req_op1,
    input  logic [31:0]                  req_op2,
    input  logic                         req_mode,
    output logic                         add_start,
    output logic                         mode,
    output logic [31:0]                  op1,
    output logic [31:0]                  op2,
    input  logic [31:0]                  add_result,
    input  logic                         add_done,
    input  logic                         add_overflow,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [31:0]                  rsp_result,
    output logic                         rsp_overflow,
    output logic                         rsp_timeout,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, HOLD = 2'd3;

    logic [1:0]    state;
    logic [64:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0] timer;
    logic          push, pop;

    // ready is gated by reset so every output reads 0 while n_rst is low
    assign req_ready = n_rst && (fifo_count != CW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (fifo_count != '0);
    assign add_start = (state == ISSUE);
    assign rsp_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {req_mode, req_op1, req_op2};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            timer        <= '0;
            mode         <= 1'b0;
            op1          <= '0;
            op2          <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    {mode, op1, op2} <= mem[rd_ptr];
                    state            <= ISSUE;
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: if (add_done) begin
                    rsp_result   <= add_result;
                    rsp_overflow <= add_overflow;
                    rsp_timeout  <= 1'b0;
                    state        <= HOLD;
                end else if (timer == TW'(TIMEOUT-1)) begin
                    rsp_result   <= '0;
                    rsp_overflow <= 1'b0;
                    rsp_timeout  <= 1'b1;
                    state        <= HOLD;
                end else begin
                    timer <= timer + 1'b1;
                end
                default: if (rsp_ready) state <= IDLE;
            endcase
        end
    end
endmodule
